// File: rtl/prf_read_scheduler_pkg.sv
// prf_read_scheduler_pkg: issue-side types and constants shared by the PRF read scheduler.
package prf_read_scheduler_pkg;
    localparam int PREG_W        = 7;
    localparam int NUM_ISSUE_REQ = 3;
    localparam int REQ_ALU       = 0;
    localparam int REQ_BR        = 1;
    localparam int REQ_MEM       = 2;
    typedef struct packed {
        logic              valid;
        logic [5:0]        rob_idx;
        logic [4:0]        opcode;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic [PREG_W-1:0] pr2;
    } rs_data;
    typedef struct packed {
        rs_data      rs;
        logic [31:0] ps1_data;
        logic [31:0] ps2_data;
    } issue_pkt;
    // p0 is hardwired zero and never occupies a read port
    function automatic logic [1:0] port_need(input rs_data d);
        return {1'b0, d.pr1 != '0} + {1'b0, d.pr2 != '0};
    endfunction
    function automatic logic [1:0] req_next(input logic [1:0] i);
        return (i == 2'(REQ_MEM)) ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/prf_read_scheduler_allocator.sv
// rr_port_allocator: round-robin greedy grant with lowest-index-first read-port assignment.
module rr_port_allocator
    import prf_read_scheduler_pkg::*;
#(
    parameter int NUM_RD_PORTS = 4,
    parameter int PORT_W       = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1
) (
    input  logic [NUM_ISSUE_REQ-1:0] elig,
    input  rs_data                   req_data [NUM_ISSUE_REQ],
    input  logic [1:0]               rr_ptr,
    output logic [NUM_ISSUE_REQ-1:0] grant,
    output logic [NUM_RD_PORTS-1:0]  port_en,
    output logic [PREG_W-1:0]        port_addr [NUM_RD_PORTS],
    output logic [PORT_W-1:0]        src1_port [NUM_ISSUE_REQ],
    output logic [PORT_W-1:0]        src2_port [NUM_ISSUE_REQ],
    output logic [1:0]               first_grant
);
    always_comb begin
        int         used;
        logic [1:0] idx;
        logic       found;
        grant       = '0;
        port_en     = '0;
        port_addr   = '{default: '0};
        src1_port   = '{default: '0};
        src2_port   = '{default: '0};
        first_grant = '0;
        used        = 0;
        idx         = rr_ptr;
        found       = 1'b0;
        for (int k = 0; k < NUM_ISSUE_REQ; k++) begin
            if (elig[idx] && int'(port_need(req_data[idx])) <= NUM_RD_PORTS - used) begin
                grant[idx] = 1'b1;
                if (!found) first_grant = idx;
                found = 1'b1;
                if (req_data[idx].pr1 != '0) begin
                    port_en[PORT_W'(used)]   = 1'b1;
                    port_addr[PORT_W'(used)] = req_data[idx].pr1;
                    src1_port[idx]           = PORT_W'(used);
                    used++;
                end
                if (req_data[idx].pr2 != '0) begin
                    port_en[PORT_W'(used)]   = 1'b1;
                    port_addr[PORT_W'(used)] = req_data[idx].pr2;
                    src2_port[idx]           = PORT_W'(used);
                    used++;
                end
            end
            idx = req_next(idx);
        end
    end
endmodule

// File: rtl/prf_read_scheduler.sv
// prf_read_scheduler: shares PRF read ports among ALU/BR/MEM issue and holds one operand-ready op per FU.
module prf_read_scheduler
    import prf_read_scheduler_pkg::*;
#(
    parameter int NUM_RD_PORTS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [NUM_ISSUE_REQ-1:0]       req_valid,
    input  rs_data                         req_data [NUM_ISSUE_REQ],
    output logic [NUM_ISSUE_REQ-1:0]       req_ready,
    output logic [NUM_RD_PORTS-1:0]        prf_rd_en,
    output logic [NUM_RD_PORTS*PREG_W-1:0] prf_rd_addr,
    input  logic [NUM_RD_PORTS*32-1:0]     prf_rd_data,
    output logic [NUM_ISSUE_REQ-1:0]       fu_valid,
    input  logic [NUM_ISSUE_REQ-1:0]       fu_ready,
    output issue_pkt                       fu_op [NUM_ISSUE_REQ]
);
    localparam int PORT_W = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    logic [1:0]               rr_ptr;
    logic [1:0]               first_grant;
    logic [NUM_ISSUE_REQ-1:0] elig;
    logic [NUM_ISSUE_REQ-1:0] grant;
    logic [PREG_W-1:0]        port_addr [NUM_RD_PORTS];
    logic [PORT_W-1:0]        src1_port [NUM_ISSUE_REQ];
    logic [PORT_W-1:0]        src2_port [NUM_ISSUE_REQ];
    logic [31:0]              rd_data [NUM_RD_PORTS];
    issue_pkt                 cap [NUM_ISSUE_REQ];
    rr_port_allocator #(.NUM_RD_PORTS(NUM_RD_PORTS), .PORT_W(PORT_W)) u_alloc (
        .elig        (elig),
        .req_data    (req_data),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .port_en     (prf_rd_en),
        .port_addr   (port_addr),
        .src1_port   (src1_port),
        .src2_port   (src2_port),
        .first_grant (first_grant)
    );
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        assign rd_data[p]                        = prf_rd_data[p*32 +: 32];
        assign prf_rd_addr[p*PREG_W +: PREG_W]   = port_addr[p];
    end
    // a full slot still accepts a new op when its FU drains it this same cycle
    for (genvar i = 0; i < NUM_ISSUE_REQ; i++) begin : g_req
        assign elig[i] = rst_n && !flush && req_valid[i] && req_data[i].valid && (!fu_valid[i] || fu_ready[i]);
        assign cap[i]  = '{rs:       req_data[i],
                           ps1_data: (req_data[i].pr1 == '0) ? 32'd0 : rd_data[src1_port[i]],
                           ps2_data: (req_data[i].pr2 == '0) ? 32'd0 : rd_data[src2_port[i]]};
    end
    assign req_ready = grant;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_valid <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_ISSUE_REQ; i++) fu_op[i] <= '0;
        end else if (flush) begin
            fu_valid <= '0;
        end else begin
            if (|grant) rr_ptr <= req_next(first_grant);
            for (int i = 0; i < NUM_ISSUE_REQ; i++) begin
                if (grant[i]) begin
                    fu_valid[i] <= 1'b1;
                    fu_op[i]    <= cap[i];
                end else if (fu_ready[i]) begin
                    fu_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_prf_read_scheduler.sv
// tb_prf_read_scheduler: directed vectors on 4-port and 3-port instances, checked against a rule-level model.
module tb_prf_read_scheduler;
    import prf_read_scheduler_pkg::*;
    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         flush     = 1'b0;
    logic [2:0]   req_valid = '0;
    logic [2:0]   fu_ready  = '0;
    rs_data       req_data [3];
    logic [2:0]   ready4, fv4, ready3, fv3;
    logic [3:0]   en4;
    logic [2:0]   en3;
    logic [27:0]  addr4;
    logic [20:0]  addr3;
    logic [127:0] data4;
    logic [95:0]  data3;
    issue_pkt     op4 [3];
    issue_pkt     op3 [3];
    int           compared   = 0;
    int           mismatched = 0;
    int           tag        = 0;
    logic [2:0]   m_fv [2];
    issue_pkt     m_op [2][3];
    int           m_rr [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] prf_val(input logic [6:0] r);
        return {8'hA5, 5'h0, r, 5'h0, r};
    endfunction

    prf_read_scheduler #(.NUM_RD_PORTS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready4), .prf_rd_en(en4), .prf_rd_addr(addr4), .prf_rd_data(data4),
        .fu_valid(fv4), .fu_ready(fu_ready), .fu_op(op4));
    prf_read_scheduler #(.NUM_RD_PORTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_data(req_data),
        .req_ready(ready3), .prf_rd_en(en3), .prf_rd_addr(addr3), .prf_rd_data(data3),
        .fu_valid(fv3), .fu_ready(fu_ready), .fu_op(op3));

    for (genvar p = 0; p < 4; p++) begin : g_prf4
        assign data4[p*32 +: 32] = prf_val(addr4[p*7 +: 7]);
    end
    for (genvar p = 0; p < 3; p++) begin : g_prf3
        assign data3[p*32 +: 32] = prf_val(addr3[p*7 +: 7]);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: walk requesters from the pointer, take each one whose operands still fit
    task automatic model_alloc(input int np, input int rr, input logic [2:0] fv,
                               output logic [2:0] g, output logic [5:0] en,
                               output logic [5:0][6:0] ad, output int first);
        logic [6:0] q [$];
        g = '0; en = '0; ad = '0; first = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            int need;
            i    = (rr + k) % 3;
            need = int'(req_data[i].pr1 != 0) + int'(req_data[i].pr2 != 0);
            if (rst_n && !flush && req_valid[i] && req_data[i].valid && (!fv[i] || fu_ready[i])
                && q.size() + need <= np) begin
                g[i] = 1'b1;
                if (first < 0) first = i;
                if (req_data[i].pr1 != 0) q.push_back(req_data[i].pr1);
                if (req_data[i].pr2 != 0) q.push_back(req_data[i].pr2);
            end
        end
        foreach (q[p]) begin
            en[p] = 1'b1;
            ad[p] = q[p];
        end
    endtask

    initial begin
        logic [2:0]      g, a_ready, a_fv;
        logic [5:0]      en, a_en;
        logic [5:0][6:0] ad, a_ad;
        int              first;
        logic [2:0]      n_fv [2];
        issue_pkt        n_op [2][3];
        int              n_rr [2];
        issue_pkt        a_op [3];
        for (int j = 0; j < 2; j++) begin
            m_fv[j] = '0;
            m_rr[j] = 0;
            for (int i = 0; i < 3; i++) m_op[j][i] = '0;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int j = 0; j < 2; j++) begin
                a_en = '0;
                a_ad = '0;
                if (j == 0) begin
                    a_ready = ready4; a_fv = fv4; a_en[3:0] = en4; a_op = op4;
                    for (int p = 0; p < 4; p++) a_ad[p] = addr4[p*7 +: 7];
                end else begin
                    a_ready = ready3; a_fv = fv3; a_en[2:0] = en3; a_op = op3;
                    for (int p = 0; p < 3; p++) a_ad[p] = addr3[p*7 +: 7];
                end
                model_alloc(j == 0 ? 4 : 3, m_rr[j], m_fv[j], g, en, ad, first);
                chk($sformatf("req_ready[dut%0d]", j), a_ready, g);
                chk($sformatf("prf_rd_en[dut%0d]", j), a_en, en);
                chk($sformatf("prf_rd_addr[dut%0d]", j), a_ad, ad);
                chk($sformatf("fu_valid[dut%0d]", j), a_fv, m_fv[j]);
                for (int i = 0; i < 3; i++)
                    if (m_fv[j][i]) chk($sformatf("fu_op%0d[dut%0d]", i, j), a_op[i], m_op[j][i]);
                n_rr[j] = (first < 0) ? m_rr[j] : (first + 1) % 3;
                for (int i = 0; i < 3; i++) begin
                    n_fv[j][i] = flush ? 1'b0 : g[i] ? 1'b1 : fu_ready[i] ? 1'b0 : m_fv[j][i];
                    n_op[j][i] = g[i] ? '{rs: req_data[i],
                                          ps1_data: (req_data[i].pr1 == 0) ? 32'd0 : prf_val(req_data[i].pr1),
                                          ps2_data: (req_data[i].pr2 == 0) ? 32'd0 : prf_val(req_data[i].pr2)}
                                      : m_op[j][i];
                end
            end
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                m_fv[j] = rst_n ? n_fv[j] : 3'b000;
                m_rr[j] = rst_n ? n_rr[j] : 0;
                for (int i = 0; i < 3; i++) m_op[j][i] = rst_n ? n_op[j][i] : '0;
            end
        end
    end

    task automatic put(input int i, input logic v, input logic [6:0] a, input logic [6:0] b);
        tag++;
        req_valid[i] = v;
        req_data[i]  = '{valid: 1'b1, rob_idx: 6'(tag), opcode: 5'(i + 1), prd: 7'(tag + 32), pr1: a, pr2: b};
    endtask

    function automatic logic [6:0] rnd_reg();
        return ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
    endfunction

    initial begin
        issue_pkt exp_op;
        for (int i = 0; i < 3; i++) req_data[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        put(REQ_ALU, 1'b1, 7'd1, 7'd0);
        put(REQ_BR, 1'b1, 7'd2, 7'd0);
        put(REQ_MEM, 1'b1, 7'd3, 7'd0);
        #1 chk("fill_grant", ready4, 3'b111);
        @(negedge clk);
        #1 chk("fill_valid", fv4, 3'b111);
        chk("fill_blocked", ready4, 3'b000);
        #2 rst_n = 1'b0;
        #1 chk("rst_fu_valid4", fv4, 3'b000);
        chk("rst_fu_valid3", fv3, 3'b000);
        chk("rst_req_ready", ready4, 3'b000);
        chk("rst_rd_en", en4, 4'b0000);
        chk("rst_rd_addr", addr4, 28'd0);
        for (int i = 0; i < 3; i++) chk("rst_fu_op", op4[i], '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fu_ready = 3'b111;
        put(REQ_ALU, 1'b1, 7'd11, 7'd12);
        put(REQ_BR, 1'b1, 7'd13, 7'd14);
        put(REQ_MEM, 1'b1, 7'd15, 7'd16);
        #1 chk("t2_grant0", ready4, 3'b011);
        chk("t2_en0", en4, 4'b1111);
        chk("t2_addr0", addr4, {7'd14, 7'd13, 7'd12, 7'd11});
        exp_op = '{rs: req_data[REQ_ALU], ps1_data: prf_val(7'd11), ps2_data: prf_val(7'd12)};
        @(negedge clk);
        put(REQ_ALU, 1'b1, 7'd11, 7'd12);
        put(REQ_BR, 1'b1, 7'd13, 7'd14);
        put(REQ_MEM, 1'b1, 7'd15, 7'd16);
        #1 chk("t2_op_alu", op4[REQ_ALU], exp_op);
        chk("t2_grant1", ready4, 3'b110);
        @(negedge clk);
        put(REQ_ALU, 1'b1, 7'd11, 7'd12);
        put(REQ_BR, 1'b1, 7'd13, 7'd14);
        put(REQ_MEM, 1'b1, 7'd15, 7'd16);
        #1 chk("t2_grant2", ready4, 3'b101);
        @(negedge clk);
        put(REQ_ALU, 1'b1, 7'd0, 7'd5);
        put(REQ_BR, 1'b1, 7'd9, 7'd10);
        put(REQ_MEM, 1'b1, 7'd0, 7'd0);
        #1 chk("t3_grant", ready4, 3'b111);
        chk("t3_en", en4, 4'b0111);
        chk("t3_addr", addr4, {7'd0, 7'd10, 7'd9, 7'd5});
        exp_op = '{rs: req_data[REQ_MEM], ps1_data: 32'd0, ps2_data: 32'd0};
        @(negedge clk);
        fu_ready  = 3'b011;
        req_valid = 3'b000;
        put(REQ_MEM, 1'b1, 7'd20, 7'd21);
        #1 chk("t3_ps1_zero", op4[REQ_ALU].ps1_data, 32'd0);
        chk("t3_ps2", op4[REQ_ALU].ps2_data, prf_val(7'd5));
        for (int c = 0; c < 3; c++) begin
            chk("t4_block", ready4, 3'b000);
            chk("t4_hold_valid", fv4[REQ_MEM], 1'b1);
            chk("t4_hold_op", op4[REQ_MEM], exp_op);
            @(negedge clk);
            #1;
        end
        fu_ready = 3'b111;
        #1 chk("t4_grant", ready4, 3'b100);
        exp_op = '{rs: req_data[REQ_MEM], ps1_data: prf_val(7'd20), ps2_data: prf_val(7'd21)};
        @(negedge clk);
        req_valid = 3'b000;
        put(REQ_ALU, 1'b1, 7'd1, 7'd2);
        put(REQ_MEM, 1'b1, 7'd3, 7'd0);
        #1 chk("t4_new_valid", fv4[REQ_MEM], 1'b1);
        chk("t4_new_op", op4[REQ_MEM], exp_op);
        chk("t5_setup_grant", ready4, 3'b101);
        @(negedge clk);
        flush = 1'b1;
        put(REQ_ALU, 1'b1, 7'd1, 7'd2);
        put(REQ_BR, 1'b1, 7'd3, 7'd4);
        put(REQ_MEM, 1'b1, 7'd5, 7'd6);
        #1 chk("t5_flush_ready", ready4, 3'b000);
        chk("t5_flush_en", en4, 4'b0000);
        chk("t5_pre_valid", fv4, 3'b101);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 3'b000;
        #1 chk("t5_cleared", fv4, 3'b000);
        @(negedge clk);
        put(REQ_ALU, 1'b1, 7'd1, 7'd2);
        put(REQ_BR, 1'b1, 7'd3, 7'd4);
        put(REQ_MEM, 1'b1, 7'd5, 7'd6);
        #1 chk("t5_rr_held", ready4, 3'b110);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk("t6_rst_valid", fv4, 3'b000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        put(REQ_ALU, 1'b1, 7'd1, 7'd2);
        put(REQ_BR, 1'b1, 7'd3, 7'd4);
        put(REQ_MEM, 1'b1, 7'd5, 7'd0);
        #1 chk("t6_grant3", ready3, 3'b101);
        chk("t6_en3", en3, 3'b111);
        chk("t6_addr3", addr3, {7'd5, 7'd2, 7'd1});
        chk("t6_grant4", ready4, 3'b011);
        repeat (80) begin
            @(negedge clk);
            flush    = ($urandom_range(0, 15) == 0);
            fu_ready = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                put(i, $urandom_range(0, 3) != 0, rnd_reg(), rnd_reg());
                req_data[i].valid = ($urandom_range(0, 7) != 0);
            end
        end
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 3'b000;
        repeat (3) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
